// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and default sizes for the instruction-memory program loader.
//   state_e : loader states (IDLE, LOAD, CHECK, DONE, ERR)
//   DEPTH   : instruction memory depth in bytes (power of two)
//   ADDR_W  : log2(DEPTH)
//   DATA_W  : instruction width
//   CSUM_W  : default running-checksum width
// -----------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int CSUM_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

endpackage

// File: rtl/prog_loader_csum.sv
// -----------------------------------------------------------------------------
// prog_loader_csum
// Running modulo-2^W byte sum with synchronous clear and add-enable, plus a
// compare of the current sum against the incoming byte.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : clear the sum to 0
//   add_i   : add data_i to the sum
//   data_i  : byte to add / byte to compare against the sum
//   match_o : sum equals data_i
// -----------------------------------------------------------------------------
module prog_loader_csum
   import prog_loader_pkg::*;
#(
   parameter int W = CSUM_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         add_i,
   input  logic [W-1:0] data_i,
   output logic         match_o
);

   logic [W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr_i)      sum_d = '0;
      else if (add_i) sum_d = sum_q + data_i;   // wraps mod 2^W
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sum_q <= '0;
      else         sum_q <= sum_d;
   end

   assign match_o = (sum_q == data_i);

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Writes the processor's instruction memory from a valid/ready byte stream at
// sequential addresses 0..DEPTH-1 while holding the processor in reset, then
// releases it once the image has landed (and, optionally, its checksum byte
// matched the running sum).
// Build option: define PROG_LOADER_CHECKSUM_EN to require a trailing checksum
// byte (DEPTH+1 bytes per load) and enable err; undefined, a load is DEPTH
// bytes and err is tied to 0.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   load_req            : start a load (honoured in IDLE, DONE, ERR)
//   abort               : return to IDLE from any state, highest priority
//   byte_in/byte_valid  : stream byte and its valid
//   byte_ready          : loader can accept a byte
//   wr_en/wr_addr/wr_data : instruction memory write port
//   cpu_hold            : processor reset request, active-high
//   done / err          : image loaded and verified / checksum mismatch
// -----------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEPTH  = prog_loader_pkg::DEPTH,
   parameter int ADDR_W = prog_loader_pkg::ADDR_W,
   parameter int DATA_W = prog_loader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              abort,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                ready_q, hold_q, done_q;
   logic                accept;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic csum_clr, csum_add, csum_match;
   logic err_q;

   prog_loader_csum #(.W(DATA_W)) u_csum (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clr_i   (csum_clr),
      .add_i   (csum_add),
      .data_i  (byte_in),
      .match_o (csum_match)
   );
`endif

   assign accept = byte_valid & ready_q & ~abort;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_clr  = 1'b0;
      csum_add  = 1'b0;
`endif
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (load_req) begin
                  state_d = ST_LOAD;
                  cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_clr = 1'b1;
`endif
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cnt_q;
                  wr_data_d = byte_in;
                  cnt_d     = cnt_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_add  = 1'b1;
                  if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_CHECK;
`else
                  if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               // The checksum byte is compared, never written.
               if (accept) state_d = csum_match ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ready_q   <= 1'b0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ready_q   <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
         // Hold is released (and done raised) one cycle after DONE is entered,
         // so the processor only starts after the final write has landed.
         hold_q    <= (state_d == ST_LOAD) || (state_d == ST_CHECK) ||
                      (state_d == ST_ERR)  ||
                      ((state_d == ST_DONE) && (state_q != ST_DONE));
         done_q    <= (state_d == ST_DONE) && (state_q == ST_DONE);
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= (state_d == ST_ERR) && (state_q == ST_ERR);
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign byte_ready = ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;

endmodule
